fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the five-stage RISC-V pipeline. Owns the architectural PC, issues one instruction-memory request at a time, and delivers fetched instructions to decode as `inst_fetched_t`. It is the consumer of the execute stage's branch-redirect interface (`kill_exe` / `pc_br_tk`). On a redirect it flushes its output, discards any in-flight response, and restarts fetching at the target.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_1000`: PC loaded on reset.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `kill_exe_in` in 1: branch taken in execute; redirect request.
- `pc_br_tk_in` in ARCH_LEN: redirect target, sampled when `kill_exe_in`=1.
- `stall_in` in 1: decode cannot accept; hold the current output.
- `imem_req_valid_out` out 1: fetch request valid.
- `imem_req_addr_out` out ARCH_LEN: fetch address, word-aligned.
- `imem_req_ready_in` in 1: memory accepts the request this cycle.
- `imem_rsp_valid_in` in 1: response data valid.
- `imem_rsp_data_in` in 32: instruction word.
- `inst_fetch_out` out inst_fetched_t: fields `valid`, `pc`, `instruction`.

## Operation

- **State**
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - FSM: `REQ`, `WAIT`, `HOLD`, `DROP`.
  - Output register `inst_fetch_out`.
  - One-entry skid buffer (`skid_pc`, `skid_inst`).
- **REQ**
  - `imem_req_valid_out`=1, `imem_req_addr_out`=`pc`.
  - On `imem_req_ready_in`: `req_pc`<=`pc`, `pc`<=`pc`+4, go to WAIT.
- **WAIT**
  - `imem_req_valid_out`=0.
  - On `imem_rsp_valid_in`, if the output register is free (`valid`=0 or `stall_in`=0):
    - load `{1, req_pc, imem_rsp_data_in}` into `inst_fetch_out`;
    - go to REQ.
  - Otherwise, write the response into the skid buffer and go to HOLD.
- **HOLD**
  - No request is issued.
  - When `stall_in`=0: skid buffer moves to `inst_fetch_out`, then go to REQ.
- **DROP**
  - Entered after a kill while a request is outstanding.
  - No request is issued.
  - On `imem_rsp_valid_in`: discard the data, go to REQ.
- **Output consumption**
  - When `stall_in`=0 and no new instruction loads, `inst_fetch_out.valid`<=0.
  - While `stall_in`=1, `inst_fetch_out` is held bit-stable.
- **Kill (highest priority, any state)**
  - `pc`<=`{pc_br_tk_in[ARCH_LEN-1:2], 2'b00}`.
  - `inst_fetch_out.valid`<=0 and the skid buffer is invalidated.
  - `stall_in` is ignored that cycle.
  - Next state:
    - DROP if in WAIT, or if in REQ and `imem_req_ready_in`=1 in the same cycle (that request is issued and must be dropped);
    - DROP stays DROP;
    - REQ otherwise, including from HOLD.
- **Kill coinciding with a response**
  - The response arriving in the kill cycle is discarded.
  - If it was the only outstanding response, go to REQ, not DROP.
- **Stray responses:** `imem_rsp_valid_in` in REQ or HOLD is ignored. The bench flags it as a protocol error.
- **PC arithmetic:** `pc`+4 is modulo 2^ARCH_LEN; wrap from `32'hFFFF_FFFC` to 0 is legal.

## Timing

- **Reset values**
  - `pc`=`RESET_PC`, state=REQ.
  - `imem_req_valid_out`=0 during the reset cycle, and 1 in the first cycle after `rst` deasserts.
  - `imem_req_addr_out`=`RESET_PC`.
  - `inst_fetch_out`=all zero.
- **Request signals:** `imem_req_valid_out` and `imem_req_addr_out` are combinational from state and `pc`. The address is stable while valid=1 and ready=0.
- **Response latency:** the earliest response arrives one cycle after the request handshake.
  - Response in cycle t → `inst_fetch_out` valid in t+1, next request in t+1.
  - Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- **Redirect latency:** kill in cycle t →
  - `inst_fetch_out.valid`=0 in t+1;
  - request to the target in t+1 if nothing is outstanding;
  - otherwise in the cycle after the stale response arrives.
- **Reset mid-operation:** returns to reset values next cycle. Any response already in flight is ignored because the FSM re-enters REQ. Memory is reset concurrently.

## Structure

- **`structure_pkg`:** add `inst_fetched_t` (`valid`, `pc[ARCH_LEN-1:0]`, `instruction[31:0]`).
- **`constants_pkg`:** add `fetch_state_t` enum and `INST_BYTES`=4. Reuse existing `ARCH_LEN`.
- **Sub-modules:** none required. The skid buffer is inline registers.
- **Size:** 150–250 lines of RTL.

## Test plan

- **Reset and sequential fetch:** `rst` 1→0, memory returns instruction = address after 1 cycle → outputs pc 0x1000, 0x1004, 0x1008 with matching data, one every 2 cycles.
- **Backpressure:** `stall_in`=1 for 5 cycles while a response arrives → the 0x1004 instruction goes to the skid buffer, no new request issues, and `inst_fetch_out` holds 0x1000. After release, 0x1004 appears the next cycle.
- **Kill in WAIT:** kill with target 0x2000 while 0x1008 is outstanding → 0x1008 response discarded, next request address 0x2000, no valid 0x1008 output.
- **Kill coinciding with response:** kill with target 0x3000 in the cycle the 0x1004 response arrives → no output for 0x1004, request 0x3000 in the next cycle (no DROP).
- **Misaligned target:** kill with target 0x4006 → request address 0x4004.
- **Memory ready stall and wrap:** `imem_req_ready_in` held 0 for 4 cycles → address stable. Then `pc`=`32'hFFFF_FFFC` fetches, followed by a request at 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   ARCH_LEN        : architectural address width
//   INST_BYTES      : bytes per instruction word (PC increment)
//   fetch_state_t   : fetch FSM state encoding (ST_REQ/ST_WAIT/ST_HOLD/ST_DROP)
//   inst_fetched_t  : payload handed to decode {valid, pc, instruction}
package fetch_stage_pkg;

  localparam int unsigned ARCH_LEN   = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ  = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;
  localparam fetch_state_t ST_DROP = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [ARCH_LEN-1:0] pc;
    logic [31:0]         instruction;
  } inst_fetched_t;

  // Force an address onto an instruction-word boundary.
  function automatic logic [ARCH_LEN-1:0] align_word(input logic [ARCH_LEN-1:0] addr);
    return {addr[ARCH_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, and delivers fetched instructions to decode with a one-entry skid
// buffer for decode backpressure. Branch redirects from execute flush the
// output and discard any stale in-flight response.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   kill_exe_in           : redirect request from execute
//   pc_br_tk_in           : redirect target (realigned to a word)
//   stall_in              : decode cannot accept; hold inst_fetch_out
//   imem_req_valid_out    : request valid (combinational from state)
//   imem_req_addr_out     : request address (current PC)
//   imem_req_ready_in     : memory accepts the request
//   imem_rsp_valid_in     : response valid
//   imem_rsp_data_in      : instruction word
//   inst_fetch_out        : registered {valid, pc, instruction} to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ARCH_LEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill_exe_in,
  input  logic [ARCH_LEN-1:0] pc_br_tk_in,
  input  logic                stall_in,
  output logic                imem_req_valid_out,
  output logic [ARCH_LEN-1:0] imem_req_addr_out,
  input  logic                imem_req_ready_in,
  input  logic                imem_rsp_valid_in,
  input  logic [31:0]         imem_rsp_data_in,
  output inst_fetched_t       inst_fetch_out
);

  fetch_state_t        r_state;
  logic [ARCH_LEN-1:0] r_pc;
  logic [ARCH_LEN-1:0] r_req_pc;
  inst_fetched_t       r_out;
  logic [ARCH_LEN-1:0] r_skid_pc;
  logic [31:0]         r_skid_inst;

  fetch_state_t        w_state_nxt;
  logic [ARCH_LEN-1:0] w_pc_nxt;
  logic [ARCH_LEN-1:0] w_req_pc_nxt;
  inst_fetched_t       w_out_nxt;
  logic [ARCH_LEN-1:0] w_skid_pc_nxt;
  logic [31:0]         w_skid_inst_nxt;
  logic                w_req_fire;
  logic                w_out_free;
  logic                w_kill_to_drop;

  assign w_req_fire = (r_state == ST_REQ) && imem_req_ready_in;
  assign w_out_free = !r_out.valid || !stall_in;

  // After a kill a response is still owed if one was outstanding and did not
  // arrive this cycle, or if a request is being handed off right now.
  assign w_kill_to_drop = w_req_fire
                       || (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_rsp_valid_in);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_out_nxt       = r_out;
    w_skid_pc_nxt   = r_skid_pc;
    w_skid_inst_nxt = r_skid_inst;

    // Decode consumed the current output.
    if (!stall_in) begin
      w_out_nxt.valid = 1'b0;
    end

    case (r_state)
      ST_REQ: begin
        if (w_req_fire) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + ARCH_LEN'(INST_BYTES);
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid_in) begin
          if (w_out_free) begin
            w_out_nxt   = '{valid: 1'b1, pc: r_req_pc, instruction: imem_rsp_data_in};
            w_state_nxt = ST_REQ;
          end else begin
            w_skid_pc_nxt   = r_req_pc;
            w_skid_inst_nxt = imem_rsp_data_in;
            w_state_nxt     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_in) begin
          w_out_nxt   = '{valid: 1'b1, pc: r_skid_pc, instruction: r_skid_inst};
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid_in) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase

    // Redirect overrides everything, including stall; leaving HOLD drops the skid entry.
    if (kill_exe_in) begin
      w_pc_nxt        = align_word(pc_br_tk_in);
      w_out_nxt.valid = 1'b0;
      w_state_nxt     = w_kill_to_drop ? ST_DROP : ST_REQ;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_out       <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_out       <= w_out_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_inst <= w_skid_inst_nxt;
    end
  end

  // Request is suppressed while reset is asserted.
  assign imem_req_valid_out = (r_state == ST_REQ) && !rst;
  assign imem_req_addr_out  = r_pc;
  assign inst_fetch_out     = r_out;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one table row per clock cycle holds the
// inputs driven in that cycle and the outputs expected before its edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          kill_exe_in;
  logic [31:0]   pc_br_tk_in;
  logic          stall_in;
  logic          imem_req_valid_out;
  logic [31:0]   imem_req_addr_out;
  logic          imem_req_ready_in;
  logic          imem_rsp_valid_in;
  logic [31:0]   imem_rsp_data_in;
  inst_fetched_t inst_fetch_out;

  fetch_stage #(.RESET_PC(32'h0000_1000)) dut (
    .clk                (clk),
    .rst                (rst),
    .kill_exe_in        (kill_exe_in),
    .pc_br_tk_in        (pc_br_tk_in),
    .stall_in           (stall_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_addr_out  (imem_req_addr_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .inst_fetch_out     (inst_fetch_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kill;
    logic [31:0] tgt;
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        erv;
    logic [31:0] ea;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic kill, logic [31:0] tgt, logic stall, logic rdy,
                              logic rv, logic [31:0] rd, logic erv, logic [31:0] ea,
                              logic eov, logic [31:0] epc, logic [31:0] einst);
    vec_t v;
    v.kill = kill; v.tgt = tgt; v.stall = stall; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.erv = erv; v.ea = ea; v.eov = eov; v.epc = epc; v.einst = einst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //                 kill tgt           stl rdy rv  rd            erv ea            eov epc           einst
    // sequential fetch, then stall with response captured in skid
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_1000, 0, 32'h0,         32'h0));         // 0
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_1000, 0, 32'h0000_1004, 0, 32'h0,         32'h0));         // 1
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         1, 32'h0000_1004, 1, 32'h0000_1000, 32'h0000_1000)); // 2
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 32'h0000_1004, 0, 32'h0000_1008, 1, 32'h0000_1000, 32'h0000_1000)); // 3
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0000_1008, 1, 32'h0000_1000, 32'h0000_1000)); // 4
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0000_1008, 1, 32'h0000_1000, 32'h0000_1000)); // 5
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0000_1008, 1, 32'h0000_1000, 32'h0000_1000)); // 6
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0000_1008, 1, 32'h0000_1000, 32'h0000_1000)); // 7
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_1008, 1, 32'h0000_1004, 32'h0000_1004)); // 8
    // kill in WAIT -> DROP stale 0x1008
    vecs.push_back(mk(1, 32'h0000_2000, 0, 0, 0, 32'h0,         0, 32'h0000_100C, 0, 32'h0,         32'h0));         // 9
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_1008, 0, 32'h0000_2000, 0, 32'h0,         32'h0));         // 10
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_2000, 0, 32'h0,         32'h0));         // 11
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_2000, 0, 32'h0000_2004, 0, 32'h0,         32'h0));         // 12
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_2004, 1, 32'h0000_2000, 32'h0000_2000)); // 13
    // kill coinciding with the response -> straight to REQ
    vecs.push_back(mk(1, 32'h0000_3000, 0, 0, 1, 32'h0000_2004, 0, 32'h0000_2008, 0, 32'h0,         32'h0));         // 14
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_3000, 0, 32'h0,         32'h0));         // 15
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_3000, 0, 32'h0000_3004, 0, 32'h0,         32'h0));         // 16
    // misaligned target, kill in REQ without handshake
    vecs.push_back(mk(1, 32'h0000_4006, 0, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 32'h0000_3000, 32'h0000_3000)); // 17
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_4004, 0, 32'h0,         32'h0));         // 18
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_4004, 0, 32'h0000_4008, 0, 32'h0,         32'h0));         // 19
    // kill during a REQ handshake -> DROP until that response returns
    vecs.push_back(mk(1, 32'h0000_5000, 0, 1, 0, 32'h0,         1, 32'h0000_4008, 1, 32'h0000_4004, 32'h0000_4004)); // 20
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0000_5000, 0, 32'h0,         32'h0));         // 21
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h0000_4008, 0, 32'h0000_5000, 0, 32'h0,         32'h0));         // 22
    // memory not ready: address stable
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));         // 23
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));         // 24
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));         // 25
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));         // 26
    // PC wrap at the top of the address space
    vecs.push_back(mk(1, 32'hFFFF_FFFE, 0, 0, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));         // 27
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));         // 28
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_ABCD, 0, 32'h0000_0000, 0, 32'h0,         32'h0));         // 29
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_ABCD)); // 30
    // fill skid, then kill from HOLD while stalled; stray response in REQ
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 32'h0000_0000, 0, 32'h0000_0004, 1, 32'hFFFF_FFFC, 32'h0000_ABCD)); // 31
    vecs.push_back(mk(1, 32'h0000_6000, 1, 0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'hFFFF_FFFC, 32'h0000_ABCD)); // 32
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 32'h0000_DEAD, 1, 32'h0000_6000, 0, 32'h0,         32'h0));         // 33
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_6000, 0, 32'h0,         32'h0));         // 34
    vecs.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_6000, 0, 32'h0000_6004, 0, 32'h0,         32'h0));         // 35
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_6004, 1, 32'h0000_6000, 32'h0000_6000)); // 36
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_6004, 0, 32'h0,         32'h0));         // 37

    rst = 1'b1; kill_exe_in = 1'b0; pc_br_tk_in = '0; stall_in = 1'b0;
    imem_req_ready_in = 1'b0; imem_rsp_valid_in = 1'b0; imem_rsp_data_in = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_valid", 32'(imem_req_valid_out), 32'h0);
    chk("reset_req_addr", imem_req_addr_out, 32'h0000_1000);
    chk("reset_out_valid", 32'(inst_fetch_out.valid), 32'h0);
    chk("reset_out_pc", inst_fetch_out.pc, 32'h0);
    chk("reset_out_inst", inst_fetch_out.instruction, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      kill_exe_in       = vecs[i].kill;
      pc_br_tk_in       = vecs[i].tgt;
      stall_in          = vecs[i].stall;
      imem_req_ready_in = vecs[i].rdy;
      imem_rsp_valid_in = vecs[i].rv;
      imem_rsp_data_in  = vecs[i].rd;
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(imem_req_valid_out), 32'(vecs[i].erv));
      chk($sformatf("row%0d_req_addr", i), imem_req_addr_out, vecs[i].ea);
      chk($sformatf("row%0d_out_valid", i), 32'(inst_fetch_out.valid), 32'(vecs[i].eov));
      if (vecs[i].eov) begin
        chk($sformatf("row%0d_out_pc", i), inst_fetch_out.pc, vecs[i].epc);
        chk($sformatf("row%0d_out_inst", i), inst_fetch_out.instruction, vecs[i].einst);
      end
      @(negedge clk);
    end

    // Reset mid-operation with a request in flight
    kill_exe_in = 1'b0; stall_in = 1'b0; imem_rsp_valid_in = 1'b0;
    imem_req_ready_in = 1'b1;
    #1;
    chk("midrst_handshake_addr", imem_req_addr_out, 32'h0000_6004);
    @(negedge clk);
    imem_req_ready_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req_valid_in_reset", 32'(imem_req_valid_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid_in = 1'b1; imem_rsp_data_in = 32'h0000_BEEF;
    #1;
    chk("midrst_req_valid_after", 32'(imem_req_valid_out), 32'h1);
    chk("midrst_req_addr_after", imem_req_addr_out, 32'h0000_1000);
    chk("midrst_out_valid_after", 32'(inst_fetch_out.valid), 32'h0);
    @(negedge clk);
    imem_rsp_valid_in = 1'b0;
    #1;
    chk("midrst_stray_ignored_valid", 32'(imem_req_valid_out), 32'h1);
    chk("midrst_stray_ignored_addr", imem_req_addr_out, 32'h0000_1000);
    chk("midrst_stray_out_valid", 32'(inst_fetch_out.valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
